oam_dma_master: RTL and testbench

- CPU-bus initiator that drives the shared 64K memory bus (addr / data / rw_n / cs_n) from the requesting side.
- Implements the NES sprite DMA triggered by a write to $4014:
  - copies 256 bytes from CPU page {page, 8'h00..8'hFF} to the PPU OAM data port, $2004;
  - holds the 6502 off the bus for the duration.
- Sits between the CPU core and the system bus arbiter. The top level owns the tristate: it combines dout with data_oe onto the bidirectional data bus.

---
 rtl/nes_bus_pkg.sv | 19 +
 rtl/oam_dma_master_if.sv | 28 ++
 rtl/oam_dma_master.sv | 125 ++++++++++++
 tb/tb_oam_dma_master.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants for the NES system bus: FSM encodings, register
// addresses and the values the bus takes when nobody is driving a cycle.
package nes_bus_pkg;

  localparam logic [15:0] OAM_PORT_ADDR = 16'h2004;
  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;

  localparam logic [15:0] BUS_IDLE_ADDR = 16'h0000;
  localparam logic [7:0]  BUS_IDLE_DATA = 8'h00;
  localparam logic        BUS_IDLE_RW_N = 1'b1;
  localparam logic        BUS_IDLE_CS_N = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

endpackage

// File: rtl/oam_dma_master_if.sv
// Bundle between the sprite DMA master, the CPU-cycle strobe/$4014 decode
// and the shared system bus.
interface oam_dma_master_if;

  logic        cpu_ce;
  logic        reg_wr;
  logic [7:0]  reg_data;
  logic [7:0]  din;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        data_oe;
  logic        rw_n;
  logic        cs_n;
  logic        bus_req;
  logic        busy;
  logic        done;

  modport master (
    input  cpu_ce, reg_wr, reg_data, din,
    output addr, dout, data_oe, rw_n, cs_n, bus_req, busy, done
  );

  modport slave (
    output cpu_ce, reg_wr, reg_data, din,
    input  addr, dout, data_oe, rw_n, cs_n, bus_req, busy, done
  );

endinterface

// File: rtl/oam_dma_master.sv
// NES sprite DMA: on a $4014 write, halts the CPU and copies one 256-byte
// page to the PPU OAM data port, with every read placed on an even CPU cycle.
module oam_dma_master #(
  parameter logic [15:0] OAM_PORT_ADDR = nes_bus_pkg::OAM_PORT_ADDR,
  parameter int          DMA_LEN       = 256
) (
  input  logic clk,
  input  logic rst,
  oam_dma_master_if.master bus
);
  import nes_bus_pkg::*;

  localparam logic [7:0] LAST_INDEX = 8'(DMA_LEN - 1);

  logic [2:0]  state_reg;
  logic [7:0]  page_reg;
  logic [7:0]  index_reg;
  logic        parity_reg;
  logic [15:0] addr_reg;
  logic [7:0]  dout_reg;
  logic        data_oe_reg;
  logic        rw_n_reg;
  logic        cs_n_reg;
  logic        bus_req_reg;
  logic        busy_reg;
  logic        done_reg;

  // Bus outputs are computed for the cycle being entered, so they stay
  // stable for the whole CPU cycle regardless of how long cpu_ce stays low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      page_reg    <= 8'h00;
      index_reg   <= 8'h00;
      parity_reg  <= 1'b0;
      addr_reg    <= BUS_IDLE_ADDR;
      dout_reg    <= BUS_IDLE_DATA;
      data_oe_reg <= 1'b0;
      rw_n_reg    <= BUS_IDLE_RW_N;
      cs_n_reg    <= BUS_IDLE_CS_N;
      bus_req_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      // done is a single-clk pulse even when cpu_ce stays low afterwards
      done_reg <= 1'b0;
      if (bus.cpu_ce) begin
        parity_reg <= ~parity_reg;
        case (state_reg)
          ST_IDLE: begin
            if (bus.reg_wr) begin
              page_reg    <= bus.reg_data;
              index_reg   <= 8'h00;
              state_reg   <= ST_HALT;
              bus_req_reg <= 1'b1;
              busy_reg    <= 1'b1;
            end
          end
          ST_HALT: begin
            // parity_reg=1 here means this HALT cycle is odd, so the next one is even
            if (parity_reg) begin
              state_reg <= ST_READ;
              addr_reg  <= {page_reg, index_reg};
              rw_n_reg  <= 1'b1;
              cs_n_reg  <= 1'b0;
            end else begin
              state_reg <= ST_ALIGN;
            end
          end
          ST_ALIGN: begin
            state_reg <= ST_READ;
            addr_reg  <= {page_reg, index_reg};
            rw_n_reg  <= 1'b1;
            cs_n_reg  <= 1'b0;
          end
          ST_READ: begin
            dout_reg    <= bus.din;
            state_reg   <= ST_WRITE;
            addr_reg    <= OAM_PORT_ADDR;
            rw_n_reg    <= 1'b0;
            cs_n_reg    <= 1'b0;
            data_oe_reg <= 1'b1;
          end
          ST_WRITE: begin
            data_oe_reg <= 1'b0;
            rw_n_reg    <= 1'b1;
            if (index_reg == LAST_INDEX) begin
              state_reg   <= ST_IDLE;
              done_reg    <= 1'b1;
              bus_req_reg <= 1'b0;
              busy_reg    <= 1'b0;
              cs_n_reg    <= BUS_IDLE_CS_N;
              addr_reg    <= BUS_IDLE_ADDR;
            end else begin
              // index wraps inside 8 bits and never carries into the page
              index_reg <= index_reg + 8'd1;
              state_reg <= ST_READ;
              addr_reg  <= {page_reg, index_reg + 8'd1};
              cs_n_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg   <= ST_IDLE;
            bus_req_reg <= 1'b0;
            busy_reg    <= 1'b0;
            cs_n_reg    <= BUS_IDLE_CS_N;
            rw_n_reg    <= BUS_IDLE_RW_N;
            data_oe_reg <= 1'b0;
            addr_reg    <= BUS_IDLE_ADDR;
          end
        endcase
      end
    end
  end

  assign bus.addr    = addr_reg;
  assign bus.dout    = dout_reg;
  assign bus.data_oe = data_oe_reg;
  assign bus.rw_n    = rw_n_reg;
  assign bus.cs_n    = cs_n_reg;
  assign bus.bus_req = bus_req_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_oam_dma_master.sv
// Bench for oam_dma_master: a 64K RAM model serves reads, and every bus cycle
// is compared against the transfer expected from the page and cycle parity.
module tb_oam_dma_master;
  import nes_bus_pkg::*;

  typedef struct {
    logic [15:0] a;
    logic        rwn;
    logic        csn;
    logic        oe;
    logic [7:0]  dq;
    logic        br;
    logic        bsy;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oam_dma_master_if bus();
  oam_dma_master dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  logic [7:0] mem [0:65535];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU cycle: optional idle clks, then the cycle's bus values are
  // captured and the RAM answers reads before the ending cpu_ce strobe.
  task automatic strobe(input bit wr, input logic [7:0] wd, input int gap,
                        output snap_t s, output logic dn);
    for (int g = 0; g < gap; g++) begin
      bus.cpu_ce   = 1'b0;
      bus.reg_wr   = 1'($urandom_range(0, 1));
      bus.reg_data = 8'($urandom);
      tick();
    end
    s.a = bus.addr; s.rwn = bus.rw_n; s.csn = bus.cs_n; s.oe = bus.data_oe;
    s.dq = bus.dout; s.br = bus.bus_req; s.bsy = bus.busy;
    bus.cpu_ce   = 1'b1;
    bus.reg_wr   = wr;
    bus.reg_data = wd;
    bus.din      = (!s.csn && s.rwn) ? mem[s.a] : 8'($urandom);
    tick();
    cyc_cnt++;
    dn = bus.done;
    bus.cpu_ce = 1'b0;
    bus.reg_wr = 1'b0;
  endtask

  task automatic run_dma(input string name, input logic [7:0] page, input int gapmax,
                         input int retrig_at, input int rst_at);
    int          exp_len;
    int          exp_first;
    int          k;
    int          first_k;
    int          mis_rd;
    int          mis_wr;
    int          bad_par;
    int          bad_oe;
    int          bad_req;
    bit          seen_done;
    bit          wr;
    snap_t       s;
    logic        dn;
    logic [15:0] rd_q[$];
    logic [7:0]  wr_q[$];
    logic [15:0] wa_q[$];
    exp_len   = (cyc_cnt % 2 == 0) ? 513 : 514;
    exp_first = (cyc_cnt % 2 == 0) ? 2 : 3;
    k = 0; first_k = -1; mis_rd = 0; mis_wr = 0; bad_par = 0; bad_oe = 0; bad_req = 0;
    seen_done = 1'b0;
    strobe(1'b1, page, (gapmax > 0) ? $urandom_range(0, gapmax) : 0, s, dn);
    while (!seen_done && k < 600) begin
      if (rst_at >= 0 && !bus.cs_n && bus.rw_n && bus.addr == {page, 8'(rst_at)}) begin
        #2 rst = 1'b1;
        #1;
        check_val({name, ".rst_cs_n"}, 32'(bus.cs_n), 32'd1);
        check_val({name, ".rst_bus_req"}, 32'(bus.bus_req), 32'd0);
        check_val({name, ".rst_data_oe"}, 32'(bus.data_oe), 32'd0);
        check_val({name, ".rst_busy"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc_cnt = 0;
        return;
      end
      wr = (retrig_at >= 0 && rd_q.size() == retrig_at);
      strobe(wr, 8'h07, (gapmax > 0) ? $urandom_range(0, gapmax) : 0, s, dn);
      k++;
      if (!s.br || !s.bsy) bad_req++;
      if (!s.csn) begin
        if (first_k < 0) first_k = k;
        if (s.rwn) begin
          rd_q.push_back(s.a);
          if ((cyc_cnt - 1) % 2 != 0) bad_par++;
          if (s.oe) bad_oe++;
        end else begin
          wa_q.push_back(s.a);
          wr_q.push_back(s.dq);
          if (!s.oe) bad_oe++;
        end
      end
      seen_done = dn;
    end
    check_val({name, ".done_seen"}, 32'(seen_done), 32'd1);
    check_val({name, ".cycles"}, 32'(k), 32'(exp_len));
    check_val({name, ".first_read_cycle"}, 32'(first_k), 32'(exp_first));
    check_val({name, ".n_reads"}, 32'(rd_q.size()), 32'd256);
    check_val({name, ".n_writes"}, 32'(wr_q.size()), 32'd256);
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== {page, 8'(i)}) mis_rd++;
    for (int i = 0; i < wr_q.size(); i++)
      if (wa_q[i] !== OAM_PORT_ADDR || wr_q[i] !== mem[{page, 8'(i)}]) mis_wr++;
    check_val({name, ".read_addr_errs"}, 32'(mis_rd), 32'd0);
    check_val({name, ".write_errs"}, 32'(mis_wr), 32'd0);
    check_val({name, ".odd_reads"}, 32'(bad_par), 32'd0);
    check_val({name, ".data_oe_errs"}, 32'(bad_oe), 32'd0);
    check_val({name, ".bus_req_drops"}, 32'(bad_req), 32'd0);
    if (rd_q.size() == 256) check_val({name, ".last_read"}, 32'(rd_q[255]), 32'({page, 8'hFF}));
    check_val({name, ".busy_after"}, 32'(bus.busy), 32'd0);
    check_val({name, ".bus_req_after"}, 32'(bus.bus_req), 32'd0);
    check_val({name, ".cs_n_after"}, 32'(bus.cs_n), 32'd1);
    tick();
    check_val({name, ".done_one_clk"}, 32'(bus.done), 32'd0);
  endtask

  task automatic align_to(input int par);
    snap_t s;
    logic  dn;
    if (cyc_cnt % 2 != par) strobe(1'b0, 8'h00, 0, s, dn);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++)
      mem[a] = (a[15:8] == 8'h02) ? (a[7:0] ^ 8'h5A) : 8'($urandom);
    rst = 1'b1;
    bus.cpu_ce = 1'b0; bus.reg_wr = 1'b0; bus.reg_data = 8'h00; bus.din = 8'h00;
    repeat (3) tick();
    check_val("reset.addr", 32'(bus.addr), 32'h0);
    check_val("reset.dout", 32'(bus.dout), 32'h0);
    check_val("reset.data_oe", 32'(bus.data_oe), 32'd0);
    check_val("reset.rw_n", 32'(bus.rw_n), 32'd1);
    check_val("reset.cs_n", 32'(bus.cs_n), 32'd1);
    check_val("reset.bus_req", 32'(bus.bus_req), 32'd0);
    check_val("reset.busy", 32'(bus.busy), 32'd0);
    check_val("reset.done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc_cnt = 0;
    tick();

    align_to(0);
    run_dma("basic", 8'h02, 0, -1, -1);
    align_to(1);
    run_dma("align", 8'h41, 0, -1, -1);
    align_to(0);
    run_dma("page_ff", 8'hFF, 0, -1, -1);
    run_dma("retrigger", 8'h02, 0, 50, -1);
    run_dma("reset_mid", 8'h02, 0, -1, 100);
    tick();
    run_dma("after_reset", 8'h03, 0, -1, -1);
    align_to(0);
    run_dma("ce_gaps", 8'h02, 5, -1, -1);
    align_to(1);
    run_dma("ce_gaps_align", 8'h02, 5, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
